// File: rtl/cpu_pkg.sv
// Shared types for the decode-stage hazard/bypass scoreboard.
package cpu_pkg;

  localparam int CPU_REG_W   = 5;
  localparam int CPU_LAT_W   = 2;
  localparam int BYP_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [CPU_REG_W-1:0] reg_d;
    logic [CPU_LAT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/cpu_bypass_match.sv
// Combinational priority matcher: youngest in-flight writer of one source operand.
// Returns the bypass stage (0 = register file) or a hazard if that writer is not ready.
module cpu_bypass_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] i_entries,
  input  logic [CPU_REG_W-1:0]  i_reg,
  input  logic                  i_use,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_hazard
);

  logic w_found;

  // Index 0 is S1, so the first hit in ascending order is the youngest writer.
  always_comb begin
    o_sel    = SEL_W'(BYP_REGFILE);
    o_hazard = 1'b0;
    w_found  = 1'b0;
    if (i_use && (i_reg != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_found && i_entries[k].valid && (i_entries[k].reg_d == i_reg)) begin
          w_found = 1'b1;
          if (i_entries[k].cnt == '0) o_sel = SEL_W'(k + 1);
          else                        o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight writes over DEPTH stages, drives bypass selects and bubble.
// Optional bubble counter output stat_bubbles under `CPU_SCOREBOARD_STATS_EN.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter  int DEPTH       = 2,
  parameter  int REG_W       = CPU_REG_W,
  parameter  int LAT_W       = CPU_LAT_W,
  parameter  int FLUSH_DEPTH = 2,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_reg_a,
  input  logic             iss_use_a,
  input  logic [REG_W-1:0] iss_reg_b,
  input  logic             iss_use_b,
  input  logic [REG_W-1:0] iss_reg_d,
  input  logic             iss_write_en,
  input  logic [LAT_W-1:0] iss_latency,
  output logic             bubble,
  output logic [SEL_W-1:0] byp_sel_a,
  output logic [SEL_W-1:0] byp_sel_b,
  output logic [REG_W-1:0] wb_reg_d,
  output logic             wb_write_en
`ifdef CPU_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stat_bubbles
`endif
);

  // The entry type is fixed by the package, so the widths must agree with it.
  if (REG_W != CPU_REG_W || LAT_W != CPU_LAT_W) begin : g_width_check
    $error("cpu_scoreboard: REG_W/LAT_W must match cpu_pkg");
  end

  sb_entry_t [DEPTH-1:0] r_stage;
  sb_entry_t [DEPTH-1:0] w_dec;
  sb_entry_t [DEPTH-1:0] w_next;
  sb_entry_t             w_issue;
  logic                  w_haz_a;
  logic                  w_haz_b;

  cpu_bypass_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .i_entries (r_stage),
    .i_reg     (iss_reg_a),
    .i_use     (iss_use_a),
    .o_sel     (byp_sel_a),
    .o_hazard  (w_haz_a)
  );

  cpu_bypass_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .i_entries (r_stage),
    .i_reg     (iss_reg_b),
    .i_use     (iss_use_b),
    .o_sel     (byp_sel_b),
    .o_hazard  (w_haz_b)
  );

  assign bubble = iss_valid & ~flush & (w_haz_a | w_haz_b);

  always_comb begin
    w_issue.valid = iss_valid & iss_write_en & (iss_reg_d != '0) & ~bubble & ~flush;
    w_issue.reg_d = iss_reg_d;
    w_issue.cnt   = iss_latency;
  end

  // Counters run every cycle, even while stalled, so a held load still becomes ready.
  always_comb begin
    w_dec = r_stage;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_stage[k].valid && (r_stage[k].cnt != '0)) w_dec[k].cnt = r_stage[k].cnt - 1'b1;
    end
  end

  always_comb begin
    w_next = w_dec;
    if (!stall) begin
      w_next[0] = w_issue;
      for (int k = 1; k < DEPTH; k++) w_next[k] = w_dec[k-1];
    end
    if (flush) begin
      for (int k = 0; k < FLUSH_DEPTH; k++) w_next[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_stage <= '0;
    else       r_stage <= w_next;
  end

  assign wb_reg_d    = r_stage[DEPTH-1].reg_d;
  assign wb_write_en = r_stage[DEPTH-1].valid;

`ifdef CPU_SCOREBOARD_STATS_EN
  logic [31:0] r_stat_bubbles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                r_stat_bubbles <= '0;
    else if (bubble && !stall) r_stat_bubbles <= r_stat_bubbles + 32'd1;
  end

  assign stat_bubbles = r_stat_bubbles;
`endif

  always @(posedge clock) begin
    if (!reset) begin
      assert (!(iss_valid && (int'(iss_latency) > DEPTH - 1)))
        else $error("cpu_scoreboard: iss_latency %0d exceeds DEPTH-1", iss_latency);
      assert (!(r_stage[DEPTH-1].valid && (r_stage[DEPTH-1].cnt != '0)))
        else $error("cpu_scoreboard: writeback entry still has latency pending");
    end
  end

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed bench for cpu_scoreboard (DEPTH=2); stat_bubbles checked when CPU_SCOREBOARD_STATS_EN is defined.
module tb_cpu_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       iss_valid = 1'b0;
  logic [4:0] iss_reg_a = '0;
  logic       iss_use_a = 1'b0;
  logic [4:0] iss_reg_b = '0;
  logic       iss_use_b = 1'b0;
  logic [4:0] iss_reg_d = '0;
  logic       iss_write_en = 1'b0;
  logic [1:0] iss_latency = '0;
  logic       bubble;
  logic [1:0] byp_sel_a;
  logic [1:0] byp_sel_b;
  logic [4:0] wb_reg_d;
  logic       wb_write_en;
`ifdef CPU_SCOREBOARD_STATS_EN
  logic [31:0] stat_bubbles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  cpu_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .iss_valid    (iss_valid),
    .iss_reg_a    (iss_reg_a),
    .iss_use_a    (iss_use_a),
    .iss_reg_b    (iss_reg_b),
    .iss_use_b    (iss_use_b),
    .iss_reg_d    (iss_reg_d),
    .iss_write_en (iss_write_en),
    .iss_latency  (iss_latency),
    .bubble       (bubble),
    .byp_sel_a    (byp_sel_a),
    .byp_sel_b    (byp_sel_b),
    .wb_reg_d     (wb_reg_d),
    .wb_write_en  (wb_write_en)
`ifdef CPU_SCOREBOARD_STATS_EN
    ,
    .stat_bubbles (stat_bubbles)
`endif
  );

  // Waits for the falling edge, then applies one decode slot.
  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] lat,
                       input logic ua, input logic [4:0] ra, input logic ub, input logic [4:0] rb);
    @(negedge clock);
    stall = 1'b0; flush = 1'b0;
    iss_valid = v; iss_write_en = we; iss_reg_d = rd; iss_latency = lat;
    iss_use_a = ua; iss_reg_a = ra; iss_use_b = ub; iss_reg_b = rb;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (bubble !== 1'b0)      begin n_fail++; $display("FAIL reset_bubble got %0d want 0", bubble); end
    n_tests++; if (byp_sel_a !== 2'd0)   begin n_fail++; $display("FAIL reset_sel_a got %0d want 0", byp_sel_a); end
    n_tests++; if (byp_sel_b !== 2'd0)   begin n_fail++; $display("FAIL reset_sel_b got %0d want 0", byp_sel_b); end
    n_tests++; if (wb_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %0d want 0", wb_write_en); end
    n_tests++; if (wb_reg_d !== 5'd0)    begin n_fail++; $display("FAIL reset_wb_reg got %0d want 0", wb_reg_d); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_alu_bypass();
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 5, 0, 0);
    n_tests++; if (byp_sel_a !== 2'd1) begin n_fail++; $display("FAIL alu_sel_s1 got %0d want 1", byp_sel_a); end
    n_tests++; if (bubble !== 1'b0)    begin n_fail++; $display("FAIL alu_bubble got %0d want 0", bubble); end
    drive(1, 0, 0, 0, 1, 5, 0, 0);
    n_tests++; if (byp_sel_a !== 2'd2)   begin n_fail++; $display("FAIL alu_sel_s2 got %0d want 2", byp_sel_a); end
    n_tests++; if (wb_write_en !== 1'b1) begin n_fail++; $display("FAIL alu_wb_en got %0d want 1", wb_write_en); end
    n_tests++; if (wb_reg_d !== 5'd5)    begin n_fail++; $display("FAIL alu_wb_reg got %0d want 5", wb_reg_d); end
    idle(1);
    n_tests++; if (wb_write_en !== 1'b0) begin n_fail++; $display("FAIL alu_wb_drain got %0d want 0", wb_write_en); end
  endtask

  task automatic test_load_hazard();
    drive(1, 1, 7, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 7);
    n_tests++; if (bubble !== 1'b1)    begin n_fail++; $display("FAIL load_bubble got %0d want 1", bubble); end
    drive(1, 0, 0, 0, 0, 0, 1, 7);
    n_tests++; if (bubble !== 1'b0)    begin n_fail++; $display("FAIL load_reissue_bubble got %0d want 0", bubble); end
    n_tests++; if (byp_sel_b !== 2'd2) begin n_fail++; $display("FAIL load_sel_b got %0d want 2", byp_sel_b); end
    idle(2);
  endtask

  task automatic test_youngest_and_r0();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 3, 1, 0);
    n_tests++; if (byp_sel_a !== 2'd1) begin n_fail++; $display("FAIL young_sel_a got %0d want 1", byp_sel_a); end
    n_tests++; if (byp_sel_b !== 2'd0) begin n_fail++; $display("FAIL r0_sel_b got %0d want 0", byp_sel_b); end
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    n_tests++; if (byp_sel_b !== 2'd0)   begin n_fail++; $display("FAIL r0_sel_b_s1 got %0d want 0", byp_sel_b); end
    n_tests++; if (wb_reg_d !== 5'd3)    begin n_fail++; $display("FAIL young_wb_reg got %0d want 3", wb_reg_d); end
    idle(1);
    n_tests++; if (wb_write_en !== 1'b0) begin n_fail++; $display("FAIL r0_wb_en got %0d want 0", wb_write_en); end
    idle(1);
  endtask

  task automatic test_flush();
    drive(1, 1, 9, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); flush = 1'b1;
    drive(1, 0, 0, 0, 1, 9, 0, 0);
    n_tests++; if (byp_sel_a !== 2'd0)   begin n_fail++; $display("FAIL flush_sel_a got %0d want 0", byp_sel_a); end
    n_tests++; if (wb_write_en !== 1'b0) begin n_fail++; $display("FAIL flush_wb_en got %0d want 0", wb_write_en); end
    idle(1);
    n_tests++; if (wb_write_en !== 1'b0) begin n_fail++; $display("FAIL flush_wb_en2 got %0d want 0", wb_write_en); end
    drive(1, 1, 7, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 7); flush = 1'b1; #1;
    n_tests++; if (bubble !== 1'b0)    begin n_fail++; $display("FAIL flush_beats_bubble got %0d want 0", bubble); end
    drive(1, 0, 0, 0, 0, 0, 1, 7);
    n_tests++; if (byp_sel_b !== 2'd0) begin n_fail++; $display("FAIL flush_sel_b got %0d want 0", byp_sel_b); end
    n_tests++; if (bubble !== 1'b0)    begin n_fail++; $display("FAIL flush_after_bubble got %0d want 0", bubble); end
    idle(2);
  endtask

  task automatic test_stall();
    drive(1, 1, 4, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); stall = 1'b1;
    drive(1, 0, 0, 0, 1, 4, 0, 0);
    n_tests++; if (byp_sel_a !== 2'd1) begin n_fail++; $display("FAIL stall_sel_a got %0d want 1", byp_sel_a); end
    n_tests++; if (bubble !== 1'b0)    begin n_fail++; $display("FAIL stall_bubble got %0d want 0", bubble); end
    idle(2);
    drive(1, 1, 6, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); stall = 1'b1; flush = 1'b1;
    drive(1, 0, 0, 0, 1, 6, 0, 0);
    n_tests++; if (byp_sel_a !== 2'd0) begin n_fail++; $display("FAIL stall_flush_sel_a got %0d want 0", byp_sel_a); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 2, 0, 0, 0, 0, 0);
    drive(1, 1, 8, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 8, 0, 0);
    n_tests++; if (bubble !== 1'b1)      begin n_fail++; $display("FAIL mid_pre_bubble got %0d want 1", bubble); end
    n_tests++; if (wb_write_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wb_en got %0d want 1", wb_write_en); end
    reset = 1'b1; #1;
    n_tests++; if (bubble !== 1'b0)      begin n_fail++; $display("FAIL mid_bubble got %0d want 0", bubble); end
    n_tests++; if (byp_sel_a !== 2'd0)   begin n_fail++; $display("FAIL mid_sel_a got %0d want 0", byp_sel_a); end
    n_tests++; if (wb_write_en !== 1'b0) begin n_fail++; $display("FAIL mid_wb_en got %0d want 0", wb_write_en); end
    n_tests++; if (wb_reg_d !== 5'd0)    begin n_fail++; $display("FAIL mid_wb_reg got %0d want 0", wb_reg_d); end
    @(negedge clock); reset = 1'b0;
    idle(1);
  endtask

`ifdef CPU_SCOREBOARD_STATS_EN
  task automatic test_stats();
    @(negedge clock); reset = 1'b1; #1;
    n_tests++; if (stat_bubbles !== 32'd0) begin n_fail++; $display("FAIL stats_init got %0d want 0", stat_bubbles); end
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 7, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 7, 0, 0);
      idle(1);
    end
    n_tests++; if (stat_bubbles !== 32'd3) begin n_fail++; $display("FAIL stats_count got %0d want 3", stat_bubbles); end
    reset = 1'b1; #1;
    n_tests++; if (stat_bubbles !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d want 0", stat_bubbles); end
    @(negedge clock); reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_bypass();
    test_load_hazard();
    test_youngest_and_r0();
    test_flush();
    test_stall();
    test_reset_mid();
`ifdef CPU_SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
